// File: rtl/spike_link_tx_if.sv
// Producer-side spike word handshake between a neuron tile and its link transmitter.
interface spike_link_tx_if #(
  parameter int DATA_W = 8
);
  logic              spk_valid;
  logic [DATA_W-1:0] spk_data;
  logic              spk_ready;

  modport master (output spk_valid, output spk_data, input spk_ready);
  modport slave  (input spk_valid, input spk_data, output spk_ready);
endinterface

// File: rtl/spike_link_tx.sv
// Inter-tile spike link transmitter: buffers spike words in a small FIFO and
// sends each as a framed serial word (start, LSB-first data, even parity, stop).
module spike_link_tx #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BIT_DIV    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  spike_link_tx_if.slave              spk,
  input  logic                        link_rdy,
  output logic                        tx_line,
  output logic                        busy,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic [DW-1:0] LAST_DIV = DW'(BIT_DIV - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DW-1:0]     div_q, div_d;
  logic              tx_q, tx_d;
  logic              ovf_q, ovf_d;

  logic              full, empty, push, pop, tick;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [DATA_W-1:0] head;

  // One enabled register per FIFO entry; storage needs no reset.
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    logic [DATA_W-1:0] entry_q;
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_q == PW'(gi))) begin
        entry_q <= spk.spk_data;
      end
    end
    assign mem[gi] = entry_q;
  end

  assign full          = (count_q == DEPTH_L);
  assign empty         = (count_q == '0);
  assign spk.spk_ready = !full;
  assign push          = spk.spk_valid && !full;
  assign pop           = (state_q == S_IDLE) && !empty && link_rdy && ena;
  assign tick          = (div_q == LAST_DIV);
  assign head          = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | (spk.spk_valid && full);
  end

  // tx_d is the line level for the bit cell that begins on the next edge.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    bit_d    = bit_q;
    div_d    = div_q;
    tx_d     = tx_q;
    if (state_q == S_IDLE) begin
      if (pop) begin
        state_d  = S_START;
        shift_d  = head;
        parity_d = ^head;
        bit_d    = '0;
        div_d    = '0;
        tx_d     = 1'b0;
      end
    end else if (!tick) begin
      div_d = div_q + DW'(1);
    end else begin
      div_d = '0;
      case (state_q)
        S_START: begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
        S_DATA: begin
          if (bit_q == LAST_BIT) begin
            state_d = S_PARITY;
            tx_d    = parity_q;
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end
        S_PARITY: begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      bit_q    <= '0;
      div_q    <= '0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      tx_q     <= tx_d;
      ovf_q    <= ovf_d;
    end
  end

  assign tx_line    = tx_q;
  assign busy       = (state_q != S_IDLE);
  assign overflow   = ovf_q;
  assign fifo_level = count_q;
endmodule

// File: doc/spike_link_tx.md
Name: spike_link_tx

Overview:
- Transmit end of the inter-tile spike link for the neurochip FPNA fabric.
- Accepts parallel spike-event words from the local neuron tile over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each word onto a single-wire framed link toward the neighbouring tile's link receiver, with a receiver-ready backpressure input.

Parameters:
DATA_W  8  spike event word width (bits per frame payload)
FIFO_DEPTH  4  FIFO entries; power of two, >= 2
BIT_DIV  4  clock cycles per serial bit; >= 1

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  tile enable; gates start of new frames only
spk_valid  input  1  producer has a spike word
spk_data  input  DATA_W  spike word
spk_ready  output  1  FIFO can accept a word
link_rdy  input  1  downstream receiver ready; sampled only in IDLE
tx_line  output  1  serial link line, idle high
busy  output  1  frame in progress (state != IDLE)
overflow  output  1  sticky: spk_valid seen while FIFO full
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst_n low):
  - FIFO empty, fifo_level=0, spk_ready=1.
  - tx_line=1, busy=0, overflow=0.
  - FSM in IDLE; bit counter and divider counter at 0.
  - Reset asserted mid-frame aborts the frame immediately; tx_line returns to 1 asynchronously.
- Write side:
  - spk_ready = !full, taken from registered state only; no same-cycle pass-through of a pop.
  - Push occurs on a clock edge when spk_valid && spk_ready.
  - If spk_valid && full, the word is not accepted and overflow sets; overflow clears only on reset.
- Read side:
  - Pop occurs only on the IDLE->START transition.
  - Simultaneous push and pop: both take effect and fifo_level is unchanged.
  - FIFO pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if fifo non-empty && link_rdy && ena, pop head into the shift register and go to START. Otherwise stay.
  - START: tx_line=0 for BIT_DIV cycles, then DATA.
  - DATA: DATA_W bits, LSB first, each held BIT_DIV cycles, then PARITY.
  - PARITY: even parity (XOR of all data bits) for BIT_DIV cycles, then STOP.
  - STOP: tx_line=1 for BIT_DIV cycles, then IDLE.
- Timing:
  - Frame length is exactly (DATA_W+3)*BIT_DIV cycles.
  - tx_line is registered and changes only at bit boundaries.
  - Back-to-back frames have one IDLE cycle between STOP and START, so the minimum frame period is (DATA_W+3)*BIT_DIV+1 cycles.
- Latency: word pushed at edge N into an empty FIFO (link_rdy=1, ena=1):
  - IDLE pops at edge N+1.
  - tx_line=0 from edge N+1 onward.
- Mid-frame rules:
  - link_rdy deassertion is ignored until IDLE.
  - ena deassertion lets the current frame complete, then holds IDLE; FIFO keeps accepting words.
- busy=1 in every state except IDLE.

Test Plan:
- Reset then push 0xA5 with BIT_DIV=4:
  - tx_line must be high before the frame.
  - Frame: low 4 cycles; bits 1,0,1,0,0,1,0,1 each 4 cycles; parity 0; stop high 4 cycles.
  - Total 44 cycles; busy high throughout; fifo_level 1->0 at the pop.
- Push 0x07: parity bit must be 1.
- link_rdy=0, push 4 words 0x01..0x04:
  - fifo_level=4, spk_ready=0.
  - Push 0x05: overflow=1, fifo_level stays 4.
  - Raise link_rdy: frames carry 0x01,0x02,0x03,0x04 in order, 45 cycles apart.
  - overflow remains 1.
- Start frame 0x3C, drop ena and link_rdy at cycle 10:
  - Frame completes intact.
  - No second frame while ena=0, although FIFO holds 0x11.
  - Re-assert both: 0x11 starts 1 cycle later.
- FIFO at level 3, push during the IDLE->START pop edge: fifo_level stays 3, no overflow.
- Assert rst_n=0 at cycle 20 of a frame:
  - tx_line=1, busy=0, fifo_level=0 immediately.
  - After release, the next pushed word transmits a clean full frame.
